// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST sequencer.
package s298_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  // Feedback taps shared by LFSR and MISR: bits 15, 13, 12, 10.
  localparam logic [15:0] POLY_TAPS = 16'hB400;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting six core outputs.
import s298_bist_pkg::*;

module bist_misr #(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [5:0]       i_data,
  output logic [SIG_W-1:0] o_sig,
  output logic [SIG_W-1:0] o_next
);

  localparam logic [SIG_W-1:0] TAPS = SIG_W'(POLY_TAPS);

  logic [SIG_W-1:0] r_misr;
  logic [SIG_W-1:0] w_step;

  // Next register value; exposed so the controller can judge the final signature on the same edge.
  always_comb begin
    w_step = {r_misr[SIG_W-2:0], ^(r_misr & TAPS)} ^ {{(SIG_W-6){1'b0}}, i_data};
    o_next = r_misr;
    if (i_load) begin
      o_next = INIT;
    end else if (i_en) begin
      o_next = w_step;
    end
  end

  // Signature register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_misr <= INIT;
    end else begin
      r_misr <= o_next;
    end
  end

  assign o_sig = r_misr;

endmodule

// File: rtl/s298_bist_ctrl.sv
// BIST sequencer for the s298 core: flush, LFSR pattern drive, MISR compaction, golden compare.
import s298_bist_pkg::*;

module s298_bist_ctrl #(
  parameter int unsigned      CNT_W       = 16,
  parameter int unsigned      SIG_W       = 16,
  parameter int unsigned      INIT_CYCLES = 4,
  parameter logic [SIG_W-1:0] MISR_INIT   = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] golden,
  output logic             core_g0,
  output logic             core_g1,
  output logic             core_g2,
  input  logic [5:0]       core_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned      ICW  = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [SIG_W-1:0] TAPS = SIG_W'(POLY_TAPS);

  bist_state_t      r_state;
  bist_state_t      w_next_state;
  logic [SIG_W-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic [ICW-1:0]   r_icnt;
  logic             r_first;
  logic             r_pass;
  logic             w_start_ok;
  logic             w_misr_en;
  logic [SIG_W-1:0] w_sig_next;

  assign w_start_ok = start && !abort && (r_state == IDLE || r_state == DONE);

  // r_first stays set until the first RUN cycle passes, which both skips the
  // capture that would see pre-pattern core state and suppresses the FLUSH
  // capture when no pattern was applied (N == 0).
  assign w_misr_en = (r_state == RUN || r_state == FLUSH) && !r_first && !abort;

  // State register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and core/status outputs.
  always_comb begin
    w_next_state = r_state;
    core_g0      = 1'b0;
    core_g1      = 1'b0;
    core_g2      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_next_state = INIT;
        end
      end
      INIT: begin
        core_g0 = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          w_next_state = IDLE;
        end else if (r_icnt == '0) begin
          w_next_state = (r_cnt == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        {core_g2, core_g1, core_g0} = r_lfsr[2:0];
        busy = 1'b1;
        if (abort) begin
          w_next_state = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next_state = FLUSH;
        end
      end
      FLUSH: begin
        busy         = 1'b1;
        w_next_state = abort ? IDLE : DONE;
      end
      DONE: begin
        done = 1'b1;
        if (abort) begin
          w_next_state = IDLE;
        end else if (start) begin
          w_next_state = INIT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Seed/count capture on start, flush countdown, LFSR advance and pattern countdown.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_lfsr  <= '0;
      r_cnt   <= '0;
      r_icnt  <= '0;
      r_first <= 1'b0;
    end else if (w_start_ok) begin
      r_lfsr  <= (seed == '0) ? SIG_W'(1) : seed;
      r_cnt   <= num_patterns;
      r_icnt  <= ICW'(INIT_CYCLES - 1);
      r_first <= 1'b1;
    end else if (!abort) begin
      if (r_state == INIT && r_icnt != '0) begin
        r_icnt <= r_icnt - 1'b1;
      end
      if (r_state == RUN) begin
        r_lfsr  <= {r_lfsr[SIG_W-2:0], ^(r_lfsr & TAPS)};
        r_cnt   <= r_cnt - 1'b1;
        r_first <= 1'b0;
      end
    end
  end

  // Pass flag: judged against the signature DONE will show, held through DONE, cleared elsewhere.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_pass <= 1'b0;
    end else if (w_next_state != DONE) begin
      r_pass <= 1'b0;
    end else if (r_state != DONE) begin
      r_pass <= (w_sig_next == golden);
    end
  end

  assign pass = r_pass;

  bist_misr #(
    .SIG_W (SIG_W),
    .INIT  (MISR_INIT)
  ) u_misr (
    .i_clk  (CK),
    .i_rst  (RST),
    .i_load (w_start_ok),
    .i_en   (w_misr_en),
    .i_data (core_out),
    .o_sig  (signature),
    .o_next (w_sig_next)
  );

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Scoreboard bench for s298_bist_ctrl with a small registered stand-in for the core.
module tb_s298_bist_ctrl;

  logic        CK;
  logic        RST;
  logic        start;
  logic        abort;
  logic [15:0] seed;
  logic [15:0] num_patterns;
  logic [15:0] golden;
  logic        core_g0;
  logic        core_g1;
  logic        core_g2;
  logic [5:0]  core_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  // Stand-in core: no reset, shifts the last two G2..G0 drives, so outputs lag inputs by a cycle.
  logic [5:0] r_fc = '0;
  logic       stub_en;
  logic [5:0] stub_val;

  always @(posedge CK) r_fc <= {r_fc[2:0], core_g2, core_g1, core_g0};
  assign core_out = stub_en ? stub_val : r_fc;

  typedef struct packed {
    logic [15:0] sig;
    logic        ok;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  s298_bist_ctrl #(
    .CNT_W       (16),
    .SIG_W       (16),
    .INIT_CYCLES (4),
    .MISR_INIT   (16'h0000)
  ) dut (
    .CK           (CK),
    .RST          (RST),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .num_patterns (num_patterns),
    .golden       (golden),
    .core_g0      (core_g0),
    .core_g1      (core_g1),
    .core_g2      (core_g2),
    .core_out     (core_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic start_run(input logic [15:0] s, input logic [15:0] n, input logic [15:0] g,
                           input logic [15:0] exp_sig, input logic exp_ok, input logic push);
    seed         = s;
    num_patterns = n;
    golden       = g;
    start        = 1'b1;
    if (push) sb_q.push_back('{sig: exp_sig, ok: exp_ok});
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      step();
    end
    chk(name, {31'b0, done}, 32'd1);
  endtask

  // Cycle-by-cycle drive check for seed 1 (or 0) with N=4; begins in the first INIT cycle.
  task automatic drive_check(input string tag);
    logic [2:0] exp_drv [4];
    exp_drv = '{3'b001, 3'b010, 3'b100, 3'b000};
    chk({tag, "_init_pass"}, {31'b0, pass}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_init_g"}, {28'b0, busy, core_g2, core_g1, core_g0}, 32'b1001);
      // a start while busy must be ignored
      if (i == 1) begin
        start        = 1'b1;
        seed         = 16'h00FF;
        num_patterns = 16'd9;
      end else begin
        start = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_run_g"}, {28'b0, busy, core_g2, core_g1, core_g0}, {28'b0, 1'b1, exp_drv[i]});
      step();
    end
    chk({tag, "_flush"}, {28'b0, busy, core_g2, core_g1, core_g0}, 32'b1000);
    step();
    chk({tag, "_done"}, {30'b0, busy, done}, 32'b01);
  endtask

  // Monitor: on each rising done, pop the expected response and compare.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge CK);
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done: got done=1 want no completion");
        end else begin
          e = sb_q.pop_front();
          chk("sb_signature", {16'b0, signature}, {16'b0, e.sig});
          chk("sb_pass", {31'b0, pass}, {31'b0, e.ok});
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int nb;
    RST          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    seed         = '0;
    num_patterns = '0;
    golden       = '0;
    stub_en      = 1'b0;
    stub_val     = '0;
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    chk("rst_sig", {16'b0, signature}, 32'd0);
    chk("rst_g", {29'b0, core_g2, core_g1, core_g0}, 32'd0);
    RST = 1'b0;
    step();

    // 1: N=0 -> four INIT cycles plus FLUSH busy, signature untouched
    start_run(16'h0001, 16'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    nb = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      nb++;
      step();
    end
    chk("t1_busy_cycles", nb, 32'd5);
    chk("t1_done", {31'b0, done}, 32'd1);
    step();

    // start together with abort in DONE: abort wins, back to IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_state", {29'b0, busy, done, pass}, 32'd0);

    // 2: seed 1, N=4, golden matches
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0068, 1'b1, 1'b1);
    drive_check("t2");
    step();

    // 3: seed 0 is replaced by 1
    start_run(16'h0000, 16'd4, 16'h0068, 16'h0068, 1'b1, 1'b1);
    drive_check("t3");
    step();

    // 4: stubbed core output, one capture, golden mismatch
    stub_en  = 1'b1;
    stub_val = 6'h01;
    start_run(16'h0005, 16'd1, 16'h0002, 16'h0001, 1'b0, 1'b1);
    wait_done("t4_timeout");
    step();
    stub_en = 1'b0;

    // 5: abort in the 2nd RUN cycle, then a clean restart
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_state", {30'b0, busy, done}, 32'd0);
    chk("t5_sig_frozen", {16'b0, signature}, 32'h0000);
    chk("t5_abort_g", {29'b0, core_g2, core_g1, core_g0}, 32'd0);
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0068, 1'b1, 1'b1);
    wait_done("t5_timeout");
    step();

    // 6: async reset mid-RUN, then two runs give equal signatures
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("t6_pre_sig", {16'b0, signature}, 32'h0009);
    chk("t6_pre_g", {29'b0, core_g2, core_g1, core_g0}, 32'b100);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_sig", {16'b0, signature}, 32'd0);
    chk("t6_rst_g", {29'b0, core_g2, core_g1, core_g0}, 32'd0);
    step();
    RST = 1'b0;
    step();
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0068, 1'b1, 1'b1);
    wait_done("t6a_timeout");
    step();
    start_run(16'h0001, 16'd4, 16'h0068, 16'h0068, 1'b1, 1'b1);
    wait_done("t6b_timeout");
    step();
    step();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
